// File: rtl/bus_responder_pkg.sv
// Shared definitions for the bus responder: the peripheral address map,
// the TIMER_CTRL bit positions and the UART transmitter state encoding.
package bus_responder_pkg;

   // Peripheral register addresses. RAM occupies 0x00..RAM_DEPTH-1.
   localparam logic [6:0] ADDR_GPIO_OUT   = 7'h40;
   localparam logic [6:0] ADDR_GPIO_IN    = 7'h41;
   localparam logic [6:0] ADDR_SNAP_LO    = 7'h42;
   localparam logic [6:0] ADDR_SNAP_HI    = 7'h43;
   localparam logic [6:0] ADDR_TIMER_CTRL = 7'h44;
   localparam logic [6:0] ADDR_CMP_LO     = 7'h45;
   localparam logic [6:0] ADDR_CMP_HI     = 7'h46;
   localparam logic [6:0] ADDR_STATUS     = 7'h47;
   localparam logic [6:0] ADDR_UART_DATA  = 7'h48;
   localparam logic [6:0] ADDR_UART_STAT  = 7'h49;

   // TIMER_CTRL bit positions. CLR and SNAP are write-1 actions only.
   localparam int CTRL_EN     = 0;
   localparam int CTRL_CLR    = 1;
   localparam int CTRL_IRQ_EN = 2;
   localparam int CTRL_SNAP   = 3;

   // STATUS bit positions.
   localparam int STATUS_MATCH = 0;

   // Serial transmitter frame states.
   typedef enum logic [1:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_STOP
   } uart_state_t;

endpackage

// File: rtl/bus_responder_uart_tx.sv
// Byte-wide serial transmitter: start bit, 8 data bits LSB first, stop bit,
// each held for CLKS_PER_BIT clocks. The line output is registered so it
// never glitches; busy is high from the cycle after start until the stop
// bit has completed.
import bus_responder_pkg::*;

module uart_tx #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       tx
);

   localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  LAST_CLK = CW'(CLKS_PER_BIT - 1);

   uart_state_t   state_q, state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   // Control state register; reset abandons any frame and idles the line.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= UART_IDLE;
         clk_cnt_q <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
      end
   end

   // Shift register holds payload only, so it needs no reset.
   always_ff @(posedge clock) begin
      shift_q <= shift_d;
   end

   // Next-state logic: walk START -> DATA x8 -> STOP, one bit period each.
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = 1'b1;

      unique case (state_q)
         UART_IDLE: begin
            if (start) begin
               state_d   = UART_START;
               shift_d   = data;
               clk_cnt_d = '0;
               bit_idx_d = '0;
            end
         end
         UART_START: begin
            if (clk_cnt_q == LAST_CLK) begin
               clk_cnt_d = '0;
               state_d   = UART_DATA;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         UART_DATA: begin
            if (clk_cnt_q == LAST_CLK) begin
               clk_cnt_d = '0;
               shift_d   = {1'b0, shift_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = UART_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         UART_STOP: begin
            if (clk_cnt_q == LAST_CLK) begin
               clk_cnt_d = '0;
               state_d   = UART_IDLE;
            end else begin
               clk_cnt_d = clk_cnt_q + 1'b1;
            end
         end
         default: state_d = UART_IDLE;
      endcase

      // Line level follows the state being entered so tx_q lines up with it.
      case (state_d)
         UART_START: tx_d = 1'b0;
         UART_DATA:  tx_d = shift_d[0];
         default:    tx_d = 1'b1;
      endcase
   end

   assign busy = (state_q != UART_IDLE);
   assign tx   = tx_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-bus responder: 64-byte data RAM, GPIO, 16-bit timer with compare
// and interrupt, and an optional serial transmitter. Stores land on the
// clock edge; loads are returned combinationally with no side effects.
// Optional feature macro: BUS_RESPONDER_UART_TX_EN (UART at 0x48/0x49).
import bus_responder_pkg::*;

module bus_responder #(
   parameter int RAM_DEPTH    = 64,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [6:0] address,
   input  logic       write_enable,
   input  logic [7:0] write_data,
   output logic [7:0] read_data,
   input  logic [7:0] gpio_in,
   output logic [7:0] gpio_out,
   output logic       irq,
   output logic       uart_tx
);

   localparam int AW = $clog2(RAM_DEPTH);

   // Reject configurations the address decode cannot represent.
   if (RAM_DEPTH < 2 || RAM_DEPTH > 64 || (RAM_DEPTH & (RAM_DEPTH - 1)) != 0
       || CLKS_PER_BIT < 2) begin : g_param_check
      $error("bus_responder: RAM_DEPTH must be a power of two in 2..64, CLKS_PER_BIT >= 2");
   end

   logic [7:0]  ram_q [RAM_DEPTH];
   logic        ram_hit;
   logic [AW-1:0] ram_idx;

   logic [7:0]  gpio_out_q, gpio_out_d;
   logic [7:0]  gpio_meta_q, gpio_sync_q;
   logic        en_q, en_d;
   logic        irq_en_q, irq_en_d;
   logic [7:0]  cmp_lo_q, cmp_lo_d;
   logic [7:0]  cmp_hi_q, cmp_hi_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] snap_q, snap_d;
   logic        match_q, match_d;
   logic        irq_q, irq_d;

   logic        ctrl_wr, clr_req, snap_req, match_hit;
   logic [7:0]  rdata;

   assign ram_hit = ({25'd0, address} < RAM_DEPTH);
   assign ram_idx = address[AW-1:0];

   // RAM storage; contents are deliberately left uninitialised.
   always_ff @(posedge clock) begin
      if (write_enable && ram_hit) begin
         ram_q[ram_idx] <= write_data;
      end
   end

   // Peripheral register file with synchronous reset to zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         gpio_out_q  <= '0;
         gpio_meta_q <= '0;
         gpio_sync_q <= '0;
         en_q        <= 1'b0;
         irq_en_q    <= 1'b0;
         cmp_lo_q    <= '0;
         cmp_hi_q    <= '0;
         cnt_q       <= '0;
         snap_q      <= '0;
         match_q     <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         gpio_out_q  <= gpio_out_d;
         gpio_meta_q <= gpio_in;
         gpio_sync_q <= gpio_meta_q;
         en_q        <= en_d;
         irq_en_q    <= irq_en_d;
         cmp_lo_q    <= cmp_lo_d;
         cmp_hi_q    <= cmp_hi_d;
         cnt_q       <= cnt_d;
         snap_q      <= snap_d;
         match_q     <= match_d;
         irq_q       <= irq_d;
      end
   end

   // Store decode, timer counting and match/IRQ next-state logic.
   always_comb begin
      gpio_out_d = gpio_out_q;
      en_d       = en_q;
      irq_en_d   = irq_en_q;
      cmp_lo_d   = cmp_lo_q;
      cmp_hi_d   = cmp_hi_q;
      snap_d     = snap_q;
      cnt_d      = cnt_q;

      ctrl_wr  = write_enable && (address == ADDR_TIMER_CTRL);
      clr_req  = ctrl_wr && write_data[CTRL_CLR];
      snap_req = ctrl_wr && write_data[CTRL_SNAP];

      if (write_enable) begin
         case (address)
            ADDR_GPIO_OUT: gpio_out_d = write_data;
            ADDR_CMP_LO:   cmp_lo_d   = write_data;
            ADDR_CMP_HI:   cmp_hi_d   = write_data;
            default: ;
         endcase
      end
      if (ctrl_wr) begin
         en_d     = write_data[CTRL_EN];
         irq_en_d = write_data[CTRL_IRQ_EN];
      end

      // Snapshot captures the counter as it stood before this edge.
      if (snap_req) begin
         snap_d = cnt_q;
      end

      // A clear overrides counting and suppresses a match on the same edge.
      match_hit = en_q && !clr_req && (cnt_q == {cmp_hi_q, cmp_lo_q});
      if (clr_req) begin
         cnt_d = '0;
      end else if (en_q) begin
         cnt_d = match_hit ? 16'd0 : cnt_q + 16'd1;
      end

      // Sticky match: a new hit beats a simultaneous write-1-to-clear.
      match_d = match_q;
      if (write_enable && (address == ADDR_STATUS) && write_data[STATUS_MATCH]) begin
         match_d = 1'b0;
      end
      if (match_hit) begin
         match_d = 1'b1;
      end

      irq_d = match_q && irq_en_q;
   end

`ifdef BUS_RESPONDER_UART_TX_EN
   logic uart_busy;
   logic uart_start;

   // Bytes offered while a frame is in flight are dropped.
   assign uart_start = write_enable && (address == ADDR_UART_DATA) && !uart_busy;

   uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_uart_tx (
      .clock (clock),
      .reset (reset),
      .start (uart_start),
      .data  (write_data),
      .busy  (uart_busy),
      .tx    (uart_tx)
   );
`else
   assign uart_tx = 1'b1;
`endif

   // Load path: pure function of address and current state.
   always_comb begin
      rdata = 8'h00;
      if (ram_hit) begin
         rdata = ram_q[ram_idx];
      end else begin
         case (address)
            ADDR_GPIO_OUT:   rdata = gpio_out_q;
            ADDR_GPIO_IN:    rdata = gpio_sync_q;
            ADDR_SNAP_LO:    rdata = snap_q[7:0];
            ADDR_SNAP_HI:    rdata = snap_q[15:8];
            ADDR_TIMER_CTRL: rdata = {5'd0, irq_en_q, 1'b0, en_q};
            ADDR_CMP_LO:     rdata = cmp_lo_q;
            ADDR_CMP_HI:     rdata = cmp_hi_q;
            ADDR_STATUS:     rdata = {7'd0, match_q};
`ifdef BUS_RESPONDER_UART_TX_EN
            ADDR_UART_STAT:  rdata = {7'd0, uart_busy};
`endif
            default:         rdata = 8'h00;
         endcase
      end
   end

   assign read_data = rdata;
   assign gpio_out  = gpio_out_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: a table of bus stores/loads with a
// scoreboard of expected load data, followed by hand-written sequences for
// the synchroniser, timer/IRQ, snapshot, UART frame and mid-frame reset.
// Builds with or without BUS_RESPONDER_UART_TX_EN.
module tb_bus_responder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] address = '0;
   logic       write_enable = 1'b0;
   logic [7:0] write_data = '0;
   logic [7:0] read_data;
   logic [7:0] gpio_in = '0;
   logic [7:0] gpio_out;
   logic       irq;
   logic       uart_tx;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit         wr;
      logic [6:0] addr;
      logic [7:0] data;   // store data, or expected load data
      string      name;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb[$];

   bus_responder #(
      .RAM_DEPTH    (64),
      .CLKS_PER_BIT (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .address      (address),
      .write_enable (write_enable),
      .write_data   (write_data),
      .read_data    (read_data),
      .gpio_in      (gpio_in),
      .gpio_out     (gpio_out),
      .irq          (irq),
      .uart_tx      (uart_tx)
   );

   always #5 clock = ~clock;

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [6:0] a, input logic [7:0] d);
      address      = a;
      write_data   = d;
      write_enable = 1'b1;
      cyc();
      write_enable = 1'b0;
   endtask

   task automatic rdchk(input string name, input logic [6:0] a, input logic [7:0] exp);
      address      = a;
      write_enable = 1'b0;
      #1;
      chk(name, read_data, exp);
   endtask

   task automatic add(input bit w, input logic [6:0] a, input logic [7:0] d, input string n);
      vec_t v;
      v.wr = w; v.addr = a; v.data = d; v.name = n;
      vecs.push_back(v);
   endtask

   initial begin
      logic [7:0] exp;
      logic [9:0] frame;

      // Reset state
      repeat (3) cyc();
      chk("rst_gpio_out", gpio_out, 8'h00);
      chk("rst_irq", {7'd0, irq}, 8'h00);
      chk("rst_uart_tx", {7'd0, uart_tx}, 8'h01);
      reset = 1'b0;
      cyc();
      rdchk("rst_ctrl", 7'h44, 8'h00);
      rdchk("rst_status", 7'h47, 8'h00);
      rdchk("rst_snap_lo", 7'h42, 8'h00);

      // Table of bus stores and loads
      add(1, 7'h00, 8'hA5, "");
      add(1, 7'h3F, 8'h3C, "");
      add(0, 7'h00, 8'hA5, "ram_00");
      add(0, 7'h3F, 8'h3C, "ram_3f");
      add(0, 7'h7F, 8'h00, "unmapped_7f");
      add(1, 7'h7F, 8'h55, "");
      add(0, 7'h7F, 8'h00, "unmapped_7f_after_wr");
      add(1, 7'h20, 8'h11, "");
      add(0, 7'h20, 8'h11, "ram_20");
      add(1, 7'h45, 8'hAB, "");
      add(0, 7'h45, 8'hAB, "cmp_lo");
      add(1, 7'h46, 8'hCD, "");
      add(0, 7'h46, 8'hCD, "cmp_hi");
      add(0, 7'h4A, 8'h00, "unmapped_4a");
      add(1, 7'h48, 8'h77, "");
      add(0, 7'h48, 8'h00, "uart_data_reads0");
      add(0, 7'h00, 8'hA5, "ram_00_again");
      add(1, 7'h40, 8'h81, "");
      add(0, 7'h40, 8'h81, "gpio_out_rd");
      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            wr(vecs[i].addr, vecs[i].data);
         end else begin
            address      = vecs[i].addr;
            write_enable = 1'b0;
            sb.push_back(vecs[i].data);
            #1;
            exp = sb.pop_front();
            chk(vecs[i].name, read_data, exp);
         end
      end
      chk("gpio_out_pin", gpio_out, 8'h81);

`ifdef BUS_RESPONDER_UART_TX_EN
      // The UART_DATA store above launched a frame; let it finish.
      repeat (45) cyc();
`endif
      rdchk("uart_stat_idle", 7'h49, 8'h00);

      // GPIO input synchroniser: 2 edges of latency
      address = 7'h41;
      gpio_in = 8'h3C;
      cyc();
      rdchk("gpio_in_edge1", 7'h41, 8'h00);
      cyc();
      rdchk("gpio_in_edge2", 7'h41, 8'h3C);

      // Timer compare, MATCH and IRQ
      wr(7'h45, 8'h04);
      wr(7'h46, 8'h00);
      wr(7'h44, 8'h05);
      repeat (4) cyc();
      rdchk("match_before_cmp", 7'h47, 8'h00);
      cyc();
      rdchk("match_at_cmp", 7'h47, 8'h01);
      chk("irq_lag", {7'd0, irq}, 8'h00);
      cyc();
      chk("irq_set", {7'd0, irq}, 8'h01);
      wr(7'h44, 8'h04);
      rdchk("match_sticky", 7'h47, 8'h01);
      wr(7'h47, 8'h01);
      rdchk("match_w1c", 7'h47, 8'h00);
      cyc();
      chk("irq_clear", {7'd0, irq}, 8'h00);
      wr(7'h45, 8'h00);
      wr(7'h44, 8'h07);
      cyc();
      rdchk("match_cmp0", 7'h47, 8'h01);
      wr(7'h47, 8'h01);
      rdchk("match_set_wins", 7'h47, 8'h01);

      // Snapshot after 300 counts, then clear
      wr(7'h45, 8'hFF);
      wr(7'h46, 8'hFF);
      wr(7'h44, 8'h03);
      repeat (300) cyc();
      wr(7'h44, 8'h09);
      rdchk("snap_lo_300", 7'h42, 8'h2C);
      rdchk("snap_hi_300", 7'h43, 8'h01);
      rdchk("ctrl_masked", 7'h44, 8'h01);
      chk("irq_disabled", {7'd0, irq}, 8'h00);
      wr(7'h44, 8'h02);
      wr(7'h44, 8'h08);
      rdchk("snap_lo_clr", 7'h42, 8'h00);
      rdchk("snap_hi_clr", 7'h43, 8'h00);
      rdchk("ctrl_off", 7'h44, 8'h00);

`ifdef BUS_RESPONDER_UART_TX_EN
      // Frame for 0x5A: start, 0,1,0,1,1,0,1,0, stop
      frame = 10'b1_0101_1010_0;
      wr(7'h48, 8'h5A);
      chk("uart_bit0", {7'd0, uart_tx}, {7'd0, frame[0]});
      rdchk("uart_busy_start", 7'h49, 8'h01);
      for (int b = 1; b < 10; b++) begin
         if (b == 2) begin
            repeat (3) cyc();
            wr(7'h48, 8'hFF);
         end else begin
            repeat (4) cyc();
         end
         chk($sformatf("uart_bit%0d", b), {7'd0, uart_tx}, {7'd0, frame[b]});
      end
      repeat (3) cyc();
      rdchk("uart_busy_39", 7'h49, 8'h01);
      cyc();
      rdchk("uart_idle_40", 7'h49, 8'h00);
      repeat (8) cyc();
      chk("uart_no_second", {7'd0, uart_tx}, 8'h01);
      rdchk("uart_still_idle", 7'h49, 8'h00);
`else
      frame = '0;
      chk("uart_tied_high", {7'd0, uart_tx}, 8'h01);
      rdchk("uart_stat_unmapped", 7'h49, 8'h00);
`endif

      // Reset in the middle of operation
      wr(7'h40, 8'hF0);
      wr(7'h45, 8'h00);
      wr(7'h46, 8'h00);
      wr(7'h44, 8'h05);
      cyc();
      cyc();
      chk("irq_before_rst", {7'd0, irq}, 8'h01);
`ifdef BUS_RESPONDER_UART_TX_EN
      wr(7'h48, 8'h00);
      repeat (12) cyc();
      chk("uart_data_low", {7'd0, uart_tx}, 8'h00);
      rdchk("uart_busy_mid", 7'h49, 8'h01);
`endif
      reset = 1'b1;
      cyc();
      chk("rst_mid_tx", {7'd0, uart_tx}, 8'h01);
      chk("rst_mid_gpio", gpio_out, 8'h00);
      chk("rst_mid_irq", {7'd0, irq}, 8'h00);
      rdchk("rst_mid_busy", 7'h49, 8'h00);
      rdchk("rst_mid_status", 7'h47, 8'h00);
      reset = 1'b0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Responder end of the CPU's 7-bit-address, 8-bit-data memory bus.
- Decodes `address`, services CPU stores on the clock edge and returns load data combinationally on `read_data`.
- Contains a 64-byte data RAM plus memory-mapped peripherals: GPIO, 16-bit timer with compare and IRQ, and an optional UART transmitter.
- Sits beside the `cpu` instance inside the chip top.

Parameters:
- RAM_DEPTH, 64, bytes of data RAM. Mapped at 0x00..RAM_DEPTH-1. Must be a power of two, ≤ 64.
- CLKS_PER_BIT, 16, UART bit period in clock cycles (≥ 2). Used only with the optional feature.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- address  input  7  byte address from CPU
- write_enable  input  1  1 = store this cycle
- write_data  input  8  store data
- read_data  output  8  load data; combinational from `address` and current state
- gpio_in  input  8  external inputs, asynchronous
- gpio_out  output  8  GPIO output register
- irq  output  1  timer interrupt, level
- uart_tx  output  1  serial output; idle high

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high.
- Reset values:
  - `gpio_out` = 0x00, `irq` = 0, `uart_tx` = 1.
  - All peripheral registers = 0.
  - RAM is not reset; contents are undefined until written.
- Address map:
  - 0x00-0x3F: RAM, read/write.
  - 0x40 GPIO_OUT: read/write.
  - 0x41 GPIO_IN: read-only; value after a 2-flop synchroniser (2-cycle latency).
  - 0x42 SNAP_LO, 0x43 SNAP_HI: read-only timer snapshot.
  - 0x44 TIMER_CTRL, read/write:
    - bit0 EN.
    - bit1 CLR: write-1 action, reads 0.
    - bit2 IRQ_EN.
    - bit3 SNAP: write-1 action, reads 0.
  - 0x45 CMP_LO, 0x46 CMP_HI: read/write.
  - 0x47 STATUS: bit0 MATCH, sticky, write-1-to-clear.
  - 0x48 UART_DATA: write-only, reads 0.
  - 0x49 UART_STAT: bit0 BUSY.
  - Everything else: reads 0x00, writes ignored.
- Write timing: a store takes effect on the edge where `write_enable` = 1; the new value is visible on `read_data` the next cycle.
- Read timing: `read_data` has no read side effects and is valid whenever `address` is stable. `write_enable` does not change it.
- Timer:
  - When EN = 1, the 16-bit counter increments each cycle.
  - When counter == {CMP_HI, CMP_LO}, the next counter value is 0 and MATCH sets.
  - CMP = 0 with EN = 1: counter stays 0 and MATCH sets every cycle.
  - EN = 0: counter holds.
  - CLR: counter = 0 next cycle; CLR has priority over increment.
  - SNAP: copies the pre-edge counter value into SNAP_HI/SNAP_LO.
- MATCH and IRQ:
  - If a W1C write to STATUS and a new match occur in the same cycle, set wins.
  - `irq` = MATCH & IRQ_EN, registered (1 cycle after MATCH).
- Reset mid-operation: aborts any UART frame; `uart_tx` returns to 1 the cycle after reset.

Optional Feature:
- Macro: BUS_RESPONDER_UART_TX_EN.
- Defined:
  - A write to UART_DATA while BUSY = 0 latches the byte.
  - BUSY = 1 from the next cycle.
  - Frame: start bit (0), 8 data bits LSB first, stop bit (1); each bit lasts CLKS_PER_BIT cycles.
  - BUSY clears after the stop bit completes: 10×CLKS_PER_BIT cycles after the write edge.
  - A write while BUSY = 1 is ignored.
  - States: IDLE → START → DATA (bit index 0..7) → STOP → IDLE.
- Undefined:
  - 0x48/0x49 behave as unmapped (read 0x00).
  - `uart_tx` is tied to 1.
  - No UART logic is synthesised.

Decomposition:
- Package bus_responder_pkg holds:
  - Address constants: ADDR_GPIO_OUT … ADDR_UART_STAT.
  - TIMER_CTRL bit-index constants.
  - UART state enum typedef uart_state_t.
- One sub-module: uart_tx (parameter CLKS_PER_BIT). Ports: clock, reset, start, data[7:0], busy, tx. Instantiated only under BUS_RESPONDER_UART_TX_EN.

Test Plan:
- RAM: write 0xA5 to 0x00 and 0x3C to 0x3F, then read both → 0xA5 and 0x3C. Read 0x7F → 0x00. Write 0x55 to 0x7F, read 0x7F → 0x00.
- GPIO: write 0x81 to 0x40 → `gpio_out` = 0x81 the next cycle. Drive `gpio_in` = 0x3C → 0x41 reads 0x3C by the 3rd edge and not before the 2nd.
- Timer and IRQ: CMP = 0x0004, CTRL = 0x05 → MATCH sets on the edge where counter == 4, counter wraps to 0, `irq` = 1 one cycle later. Write 0x01 to 0x47 → MATCH clears unless a match coincides.
- Snapshot and clear: EN = 1, run 300 cycles, write SNAP → 0x42/0x43 hold the counter value at the write edge (hi ≥ 0x01). Write CLR → counter 0; CTRL reads back without bits 1 and 3.
- UART (macro defined, CLKS_PER_BIT = 4): write 0x5A to 0x48 → `uart_tx` = 0,0,1,0,1,1,0,1,0,1 at 4 cycles/bit. BUSY reads 1 until 40 cycles after the write. A second write during BUSY is not transmitted.
- Reset mid-frame: assert `reset` during the UART DATA state → `uart_tx` = 1, BUSY = 0, `gpio_out` = 0, `irq` = 0 the following cycle.
